// File: rtl/control_seq.sv
// Purpose: microcoded-style control sequencer for a single-accumulator CPU:
//          fetch (F1-F3), decode, up to three execute cycles, halt.
// Latency: all outputs registered; they reflect state_dbg in the same cycle.
// Backpressure: none; start is only honoured in IDLE and HALT is sticky until reset.
// Ports: clk/rst (async active-low), start, opcode[7:0], acc_zero in;
//        C0..C8 control strobes, alu_op[1:0], halted, state_dbg[3:0], instr_cnt[7:0] out.
module control_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] opcode,
    input  logic       acc_zero,
    output logic       C0,
    output logic       C1,
    output logic       C2,
    output logic       C3,
    output logic       C4,
    output logic       C5,
    output logic       C6,
    output logic       C7,
    output logic       C8,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic [3:0] state_dbg,
    output logic [7:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F1     = 4'd1,
        S_F2     = 4'd2,
        S_F3     = 4'd3,
        S_DECODE = 4'd4,
        S_EX1    = 4'd5,
        S_EX2    = 4'd6,
        S_EX3    = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_JMP   = 8'h05;
    localparam logic [7:0] OP_JZ    = 8'h06;
    localparam logic [7:0] OP_HLT   = 8'h07;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    state_t      state_q, state_d;
    logic [7:0]  opc_q, opc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  ctrl_q, ctrl_d;   // bit n drives Cn
    logic [1:0]  alu_q, alu_d;
    logic        halt_q, halt_d;

    // State register: every flop, including the output register, clears
    // asynchronously so a reset mid-instruction leaves no partial strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            opc_q   <= 8'h00;
            cnt_q   <= 8'h00;
            ctrl_q  <= 9'h000;
            alu_q   <= ALU_PASS;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
            halt_q  <= halt_d;
        end
    end

    // Next-state logic, opcode latch and completed-instruction counter.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_F1;
            S_F1:     state_d = S_F2;
            S_F2:     state_d = S_F3;
            S_F3:     state_d = S_DECODE;
            S_DECODE: begin
                opc_d = opcode;
                if (opcode == OP_HLT)
                    state_d = S_HALT;
                else if (opcode >= OP_LOAD && opcode <= OP_JZ)
                    state_d = S_EX1;
                else
                    state_d = S_F1;       // undefined opcodes behave as NOP
            end
            S_EX1:    state_d = (opc_q == OP_JMP || opc_q == OP_JZ) ? S_F1 : S_EX2;
            S_EX2:    state_d = S_EX3;
            S_EX3:    state_d = S_F1;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        // An instruction completes when we re-enter fetch from decode or
        // execute; the initial IDLE->F1 launch is not a completion.
        if (state_d == S_F1 &&
            (state_q == S_DECODE || state_q == S_EX1 || state_q == S_EX3))
            cnt_d = cnt_q + 8'd1;
    end

    // Output decode. It is evaluated on the state being entered so the
    // registered strobes line up with state_dbg in the same cycle. For JZ
    // the acc_zero value present on the edge into EX1 decides the jump.
    always_comb begin
        ctrl_d = 9'h000;
        alu_d  = ALU_PASS;
        halt_d = 1'b0;
        case (state_d)
            S_F1:     ctrl_d[2] = 1'b1;
            S_F2: begin
                ctrl_d[3] = 1'b1;
                ctrl_d[0] = 1'b1;
            end
            S_F3:     ctrl_d[1] = 1'b1;
            S_EX1: begin
                case (opc_d)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB: ctrl_d[8] = 1'b1;
                    OP_JMP:                            ctrl_d[7] = 1'b1;
                    OP_JZ:                             ctrl_d[7] = acc_zero;
                    default:                           ctrl_d    = 9'h000;
                endcase
            end
            S_EX2: begin
                if (opc_d == OP_STORE) ctrl_d[5] = 1'b1;
                else                   ctrl_d[3] = 1'b1;
            end
            S_EX3: begin
                case (opc_d)
                    OP_STORE: ctrl_d[6] = 1'b1;
                    OP_ADD: begin
                        ctrl_d[4] = 1'b1;
                        alu_d     = ALU_ADD;
                    end
                    OP_SUB: begin
                        ctrl_d[4] = 1'b1;
                        alu_d     = ALU_SUB;
                    end
                    default: ctrl_d[4] = 1'b1;   // LOAD: ALU passes MBR through
                endcase
            end
            S_HALT:   halt_d = 1'b1;
            default:  ctrl_d = 9'h000;
        endcase
    end

    assign C0        = ctrl_q[0];
    assign C1        = ctrl_q[1];
    assign C2        = ctrl_q[2];
    assign C3        = ctrl_q[3];
    assign C4        = ctrl_q[4];
    assign C5        = ctrl_q[5];
    assign C6        = ctrl_q[6];
    assign C7        = ctrl_q[7];
    assign C8        = ctrl_q[8];
    assign alu_op    = alu_q;
    assign halted    = halt_q;
    assign state_dbg = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_control_seq.sv
// Purpose: directed self-checking bench for control_seq.
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_control_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] opcode = 8'h00;
    logic       acc_zero = 1'b0;
    logic       C0, C1, C2, C3, C4, C5, C6, C7, C8;
    logic [1:0] alu_op;
    logic       halted;
    logic [3:0] state_dbg;
    logic [7:0] instr_cnt;
    logic [8:0] cv;

    int errors = 0;
    int checks = 0;

    control_seq dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .acc_zero(acc_zero),
        .C0(C0), .C1(C1), .C2(C2), .C3(C3), .C4(C4), .C5(C5), .C6(C6), .C7(C7), .C8(C8),
        .alu_op(alu_op), .halted(halted), .state_dbg(state_dbg), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    assign cv = {C8, C7, C6, C5, C4, C3, C2, C1, C0};

    // Mutual-exclusion properties watched on every falling edge.
    always @(negedge clk) begin
        checks++;
        if (C2 && C8) begin
            errors++;
            $display("FAIL excl_c2_c8 at %0t: C2=%b C8=%b, required not both 1", $time, C2, C8);
        end
        checks++;
        if (C3 && C6) begin
            errors++;
            $display("FAIL excl_c3_c6 at %0t: C3=%b C6=%b, required not both 1", $time, C3, C6);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, then pulse start for one cycle; returns with the DUT in F1.
    task automatic launch(input logic [7:0] op, input logic az);
        rst = 1'b0; start = 1'b0; opcode = op; acc_zero = az;
        repeat (2) step();
        rst = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (state_dbg !== 4'd0 || cv !== 9'h000 || alu_op !== 2'b00 ||
            halted !== 1'b0 || instr_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: state=%0d cv=%h alu=%b halted=%b cnt=%h, required 0/000/00/0/00",
                     state_dbg, cv, alu_op, halted, instr_cnt);
        end
        step(); step();
        rst = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (state_dbg !== 4'd0 || cv !== 9'h000) begin
                errors++;
                $display("FAIL idle_hold: state=%0d cv=%h, required 0/000", state_dbg, cv);
            end
        end
    endtask

    task automatic test_load();
        logic [3:0] es [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1};
        logic [8:0] ec [8] = '{9'h004, 9'h009, 9'h002, 9'h000, 9'h100, 9'h008, 9'h010, 9'h004};
        launch(8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (state_dbg !== es[i] || cv !== ec[i] || alu_op !== 2'b00) begin
                errors++;
                $display("FAIL load_cycle%0d: state=%0d cv=%h alu=%b, required %0d/%h/00",
                         i, state_dbg, cv, alu_op, es[i], ec[i]);
            end
            checks++;
            if (instr_cnt !== ((i == 7) ? 8'd1 : 8'd0)) begin
                errors++;
                $display("FAIL load_cnt%0d: cnt=%0d, required %0d", i, instr_cnt, (i == 7) ? 1 : 0);
            end
            if (i < 7) step();
        end
    endtask

    task automatic test_store();
        logic [3:0] es [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1};
        logic [8:0] ec [8] = '{9'h004, 9'h009, 9'h002, 9'h000, 9'h100, 9'h020, 9'h040, 9'h004};
        launch(8'h02, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (state_dbg !== es[i] || cv !== ec[i] || alu_op !== 2'b00) begin
                errors++;
                $display("FAIL store_cycle%0d: state=%0d cv=%h alu=%b, required %0d/%h/00",
                         i, state_dbg, cv, alu_op, es[i], ec[i]);
            end
            if (i < 7) step();
        end
    endtask

    task automatic test_add_sub();
        logic [7:0] ops [2] = '{8'h03, 8'h04};
        logic [1:0] alus [2] = '{2'b01, 2'b10};
        for (int k = 0; k < 2; k++) begin
            launch(ops[k], 1'b0);
            repeat (6) step();
            checks++;
            if (state_dbg !== 4'd7 || cv !== 9'h010 || alu_op !== alus[k]) begin
                errors++;
                $display("FAIL alu_ex3_op%h: state=%0d cv=%h alu=%b, required 7/010/%b",
                         ops[k], state_dbg, cv, alu_op, alus[k]);
            end
            step();
            checks++;
            if (state_dbg !== 4'd1 || alu_op !== 2'b00 || instr_cnt !== 8'd1) begin
                errors++;
                $display("FAIL alu_done_op%h: state=%0d alu=%b cnt=%0d, required 1/00/1",
                         ops[k], state_dbg, alu_op, instr_cnt);
            end
        end
    endtask

    task automatic test_jump();
        logic [7:0] ops [3] = '{8'h06, 8'h06, 8'h05};
        logic       azs [3] = '{1'b0, 1'b1, 1'b0};
        logic [8:0] ec  [3] = '{9'h000, 9'h080, 9'h080};
        for (int k = 0; k < 3; k++) begin
            launch(ops[k], azs[k]);
            repeat (4) step();
            checks++;
            if (state_dbg !== 4'd5 || cv !== ec[k]) begin
                errors++;
                $display("FAIL jump_ex1_%0d: state=%0d cv=%h, required 5/%h", k, state_dbg, cv, ec[k]);
            end
            step();
            checks++;
            if (state_dbg !== 4'd1 || instr_cnt !== 8'd1) begin
                errors++;
                $display("FAIL jump_done_%0d: state=%0d cnt=%0d, required 1/1", k, state_dbg, instr_cnt);
            end
        end
    endtask

    task automatic test_nop();
        logic [7:0] ops [2] = '{8'h00, 8'hAB};
        for (int k = 0; k < 2; k++) begin
            launch(ops[k], 1'b0);
            repeat (3) step();
            checks++;
            if (state_dbg !== 4'd4 || cv !== 9'h000) begin
                errors++;
                $display("FAIL nop_decode_op%h: state=%0d cv=%h, required 4/000", ops[k], state_dbg, cv);
            end
            step();
            checks++;
            if (state_dbg !== 4'd1 || cv !== 9'h004 || instr_cnt !== 8'd1) begin
                errors++;
                $display("FAIL nop_refetch_op%h: state=%0d cv=%h cnt=%0d, required 1/004/1",
                         ops[k], state_dbg, cv, instr_cnt);
            end
        end
    endtask

    task automatic test_halt();
        launch(8'h07, 1'b0);
        repeat (4) step();
        checks++;
        if (state_dbg !== 4'd8 || halted !== 1'b1 || cv !== 9'h000) begin
            errors++;
            $display("FAIL halt_enter: state=%0d halted=%b cv=%h, required 8/1/000", state_dbg, halted, cv);
        end
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        step();
        checks++;
        if (state_dbg !== 4'd8 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_sticky: state=%0d halted=%b, required 8/1", state_dbg, halted);
        end
    endtask

    task automatic test_wrap();
        launch(8'h00, 1'b0);
        repeat (255 * 4) step();
        checks++;
        if (instr_cnt !== 8'hFF || state_dbg !== 4'd1) begin
            errors++;
            $display("FAIL wrap_ff: cnt=%h state=%0d, required ff/1", instr_cnt, state_dbg);
        end
        repeat (4) step();
        checks++;
        if (instr_cnt !== 8'h00 || state_dbg !== 4'd1) begin
            errors++;
            $display("FAIL wrap_00: cnt=%h state=%0d, required 00/1", instr_cnt, state_dbg);
        end
    endtask

    task automatic test_mid_reset();
        launch(8'h00, 1'b0);
        repeat (8) step();
        opcode = 8'h03;
        repeat (5) step();
        checks++;
        if (state_dbg !== 4'd6 || cv !== 9'h008 || instr_cnt !== 8'd2) begin
            errors++;
            $display("FAIL add_ex2: state=%0d cv=%h cnt=%0d, required 6/008/2", state_dbg, cv, instr_cnt);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (state_dbg !== 4'd0 || cv !== 9'h000 || alu_op !== 2'b00 || instr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: state=%0d cv=%h alu=%b cnt=%0d, required 0/000/00/0",
                     state_dbg, cv, alu_op, instr_cnt);
        end
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (state_dbg !== 4'd0 || cv !== 9'h000 || instr_cnt !== 8'd0) begin
                errors++;
                $display("FAIL post_reset%0d: state=%0d cv=%h cnt=%0d, required 0/000/0",
                         i, state_dbg, cv, instr_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_add_sub();
        test_jump();
        test_nop();
        test_halt();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  in  1  system clock; all state updates on rising edge, so control outputs are stable for the datapath registers that capture on the falling edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 start  in  1  level, sampled in IDLE; 1 begins instruction fetch.
REQ-005 opcode  in  8  IR opcode field, sampled only in DECODE.
REQ-006 acc_zero  in  1  ACC==0 flag, sampled only in EX1 of JZ.
REQ-007 C0  out  1  PC increment.
REQ-008 C1  out  1  MBR->IR.
REQ-009 C2  out  1  PC->MAR.
REQ-010 C3  out  1  memory read into MBR.
REQ-011 C4  out  1  ALU result->ACC.
REQ-012 C5  out  1  ACC->MBR.
REQ-013 C6  out  1  memory write from MBR.
REQ-014 C7  out  1  IR address->PC (jump).
REQ-015 C8  out  1  IR address->MAR.
REQ-016 alu_op  out  2  00 PASS, 01 ADD, 10 SUB, 11 unused.
REQ-017 halted  out  1  high while in HALT.
REQ-018 state_dbg  out  4  current state encoding.
REQ-019 instr_cnt  out  8  count of completed instructions.

Function
REQ-020 States and encodings SHALL be IDLE=0, F1=1, F2=2, F3=3, DECODE=4, EX1=5, EX2=6, EX3=7, HALT=8.
REQ-021 Transitions:
- IDLE->F1 when start=1.
- F1->F2->F3->DECODE unconditionally.
- DECODE->HALT for opcode 0x07.
- DECODE->F1 for NOP, meaning any undefined opcode, including 0x00 and 0x08-0xFF.
- DECODE->EX1 otherwise.
REQ-022 EX1->F1 for JMP (0x05) and JZ (0x06); EX1->EX2->EX3->F1 for LOAD (0x01), STORE (0x02), ADD (0x03) and SUB (0x04).
REQ-023 The latched opcode SHALL be captured in DECODE and held until the next DECODE; EX states SHALL use the latched copy only.
REQ-024 Outputs SHALL be registered and Moore-decoded from the state and latched opcode only.
REQ-025 Per-state outputs (all others 0, alu_op=00 unless stated):
- F1: C2.
- F2: C3, C0.
- F3: C1.
- DECODE: none.
REQ-026 LOAD/ADD/SUB: EX1 C8; EX2 C3; EX3 C4 with alu_op PASS, ADD or SUB respectively.
REQ-027 STORE: EX1 C8; EX2 C5; EX3 C6.
REQ-028 JMP: EX1 C7. JZ: EX1 C7 only if acc_zero=1, else no output.
REQ-029 C2 and C8 SHALL never be high in the same cycle; C3 and C6 SHALL never be high in the same cycle.
REQ-030 instr_cnt SHALL increment by 1 on each transition into F1 from DECODE or EX1/EX3, and SHALL wrap 0xFF->0x00.
REQ-031 The transition IDLE->F1 SHALL NOT increment instr_cnt.
REQ-032 HALT SHALL persist until reset; start is ignored outside IDLE.
REQ-033 Cycle counts including fetch: NOP 4; JMP/JZ 5; LOAD/STORE/ADD/SUB 7.

Reset
REQ-034 rst=0 SHALL immediately force:
- state IDLE;
- all C outputs 0, alu_op 00, halted 0;
- instr_cnt 0x00 and latched opcode 0x00.
REQ-035 This SHALL hold at any point, including mid-instruction, with no partial completion.
REQ-036 After rst rises, the block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-037 Reset, then start=1 for 1 cycle, opcode=0x01 -> states 1,2,3,4,5,6,7,1. C2@F1; C3+C0@F2; C1@F3; C8@EX1; C3@EX2; C4 with alu_op 00 @EX3; instr_cnt=1.
REQ-038 opcode=0x02 -> EX1 C8, EX2 C5, EX3 C6; C3 never high during EX states.
REQ-039 opcode=0x06 with acc_zero=0 -> EX1 all outputs 0. Repeat with acc_zero=1 -> EX1 C7=1.
REQ-040 Opcodes 0x00 and 0xAB -> DECODE returns to F1 after 4 cycles, no EX state. Opcode 0x07 -> halted=1 and state 8; a further start pulse leaves the state unchanged.
REQ-041 Run 256 NOPs -> instr_cnt wraps to 0x00.
REQ-042 Assert rst=0 during EX2 of ADD -> outputs 0 asynchronously with no C4 pulse; state IDLE; instr_cnt 0.
REQ-043 Assertions run throughout: C2&C8 never both 1, and C3&C6 never both 1.
